// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Byte counter plus little-endian assembly of four stream bytes into one word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [1:0]  count,
    output logic        last,
    output logic [31:0] word
);

    // Byte k lands in bits [8k+7:8k]; the counter wraps to 0 after byte 3.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            word  <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept) begin
            word[{count, 3'b000} +: 8] <= byte_data;
            count                      <= count + 2'd1;
        end
    end

    assign last = accept && (count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: packs a byte stream into words, writes them to consecutive
// instruction-memory addresses and holds the core until the load completes.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_hold,
    output logic [2:0]        fsm_state,
    output logic [1:0]        byte_count
);

    // Handshake: a byte moves on every rising edge where byte_valid && byte_ready;
    // byte_ready depends only on state, never on byte_valid.

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    loader_state_t     state, next_state;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word;
    logic              accept;
    logic              last;
    logic              start_ok;
    logic              count_legal;
    logic              last_word;
    logic              pack_clear;

    assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
    assign count_legal = (word_count != '0) && (word_count <= DEPTH_W);
    // Compared one bit wider than the index so a full-depth load ends at DEPTH-1.
    assign last_word   = ({1'b0, index} + ONE_W) == count_q;
    assign accept      = byte_valid && byte_ready;
    assign pack_clear  = start_ok || (state == WRITE);
    assign fsm_state   = state;

    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pack_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .count     (byte_count),
        .last      (last),
        .word      (word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = count_legal ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (last) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? DONE : LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address/data follow the live index and word during WRITE, then hold.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_hold  = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = index;
                mem_wdata = word;
            end
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            index   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start_ok) begin
                count_q <= word_count;
                index   <= '0;
            end
            if (state == WRITE) begin
                addr_q  <= index;
                wdata_q <= word;
                if (!last_word) begin
                    index <= index + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: random byte streams checked against a word-packing model.
module tb_instruction_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock      = 1'b0;
    logic              reset      = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data  = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              core_hold;
    logic [2:0]        fsm_state;
    logic [1:0]        byte_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream_q[$];
    logic [36:0] exp_q[$];
    logic [36:0] act_q[$];

    always #5 clock = ~clock;

    instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .core_hold  (core_hold),
        .fsm_state  (fsm_state),
        .byte_count (byte_count)
    );

    // Collect every write; done must never coincide with a write strobe.
    always @(negedge clock) begin
        if (reset && mem_we) begin
            act_q.push_back({mem_addr, mem_wdata});
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL we_done_overlap: done=%b required 0 while mem_we=1", done);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic fill_stream(input int n);
        stream_q.delete();
        for (int i = 0; i < n; i++) stream_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word w is bytes 4w..4w+3, little-endian, written at address w.
    task automatic build_expected(input int nwords);
        logic [31:0] data;
        exp_q.delete();
        for (int w = 0; w < nwords; w++) begin
            data = 32'd0;
            for (int k = 0; k < 4; k++) data = data + (32'(stream_q[4*w+k]) << (8*k));
            exp_q.push_back({5'(w), data});
        end
    endtask

    task automatic check_writes(input string name);
        total++;
        if (act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d writes required %0d", name, act_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (act_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d: got addr=%0d data=%h required addr=%0d data=%h",
                             name, i, act_q[i][36:32], act_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
                end
            end
        end
    endtask

    task automatic do_start(input int c);
        start      = 1'b1;
        word_count = 6'(c);
        @(posedge clock); #1;
        start      = 1'b0;
        word_count = 6'($urandom_range(0, 63));
    endtask

    // Streams stream_q[0..n-1]; optionally stalls the source and pokes start.
    task automatic drive_stream(input int n, input bit rand_valid, input bit poke_start);
        int idx = 0;
        int cycles = 0;
        bit rdy;
        bit pend = 0;
        int exp_addr = 0;
        while (idx < n && cycles < 5000) begin
            if (rand_valid && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = stream_q[idx];
            end
            if (poke_start) begin
                start      = ($urandom_range(0, 3) == 0);
                word_count = 6'($urandom_range(0, 63));
            end
            @(negedge clock);
            rdy = byte_ready;
            if (pend) begin
                pend = 0;
                total++;
                if (mem_we !== 1'b1 || byte_ready !== 1'b0 || mem_addr !== 5'(exp_addr)) begin
                    bad++;
                    $display("FAIL write_latency: got we=%b ready=%b addr=%0d required we=1 ready=0 addr=%0d",
                             mem_we, byte_ready, mem_addr, exp_addr);
                end
            end
            @(posedge clock); #1;
            if (byte_valid && rdy) begin
                idx++;
                if (idx % 4 == 0) begin
                    pend = 1;
                    exp_addr = idx / 4 - 1;
                end
            end
            cycles++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        total++;
        if (idx != n) begin
            bad++;
            $display("FAIL stream_timeout: got %0d bytes accepted required %0d", idx, n);
        end
    endtask

    // Called right after the last byte: one WRITE cycle, then DONE.
    task automatic wait_finish(input bit poke);
        @(negedge clock);
        total++;
        if (mem_we !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL last_write: got we=%b done=%b required we=1 done=0", mem_we, done);
        end
        if (poke) begin
            start      = 1'b1;
            word_count = 6'd3;
        end
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        total++;
        if ({done, core_hold, busy, error, byte_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL done_state: got done=%b hold=%b busy=%b err=%b ready=%b required 1 0 0 0 0",
                     done, core_hold, busy, error, byte_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        total++;
        if ({byte_ready, mem_we, busy, done, error} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%b we=%b busy=%b done=%b err=%b required all 0",
                     byte_ready, mem_we, busy, done, error);
        end
        total++;
        if (core_hold !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: got %b required 1", core_hold);
        end
        total++;
        if (mem_addr !== 5'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_mem: got addr=%0d data=%h required 0 0", mem_addr, mem_wdata);
        end
        total++;
        if (byte_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_byte_count: got %0d required 0", byte_count);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (core_hold !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got hold=%b busy=%b required 1 0", core_hold, busy);
        end
    endtask

    task automatic test_two_words(input bit rand_valid, input bit poke);
        stream_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        act_q.delete();
        do_start(2);
        total++;
        if (byte_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_entry: got ready=%b busy=%b required 1 1", byte_ready, busy);
        end
        drive_stream(8, rand_valid, poke);
        wait_finish(1'b0);
        build_expected(2);
        total++;
        if (exp_q[1][31:0] !== 32'h0010_0093) begin
            bad++;
            $display("FAIL model_word1: got %h required 00100093", exp_q[1][31:0]);
        end
        check_writes(rand_valid ? "two_words_stall" : "two_words");
    endtask

    task automatic test_error();
        int bad_counts[3] = '{0, 33, 63};
        foreach (bad_counts[i]) begin
            act_q.delete();
            do_start(bad_counts[i]);
            total++;
            if ({error, core_hold, busy, byte_ready, done} !== 5'b11000) begin
                bad++;
                $display("FAIL err_entry_%0d: got err=%b hold=%b busy=%b ready=%b done=%b required 1 1 0 0 0",
                         bad_counts[i], error, core_hold, busy, byte_ready, done);
            end
            repeat (6) @(posedge clock);
            #1;
            total++;
            if (error !== 1'b1 || act_q.size() != 0) begin
                bad++;
                $display("FAIL err_sticky_%0d: got err=%b writes=%0d required 1 0", bad_counts[i], error, act_q.size());
            end
            fill_stream(4);
            do_start(1);
            total++;
            if (error !== 1'b0 || byte_ready !== 1'b1) begin
                bad++;
                $display("FAIL err_clear: got err=%b ready=%b required 0 1", error, byte_ready);
            end
            drive_stream(4, 1'b0, 1'b0);
            wait_finish(1'b0);
            build_expected(1);
            check_writes("err_recover");
        end
    endtask

    task automatic test_full_depth();
        fill_stream(4 * DEPTH);
        act_q.delete();
        do_start(DEPTH);
        drive_stream(4 * DEPTH, 1'b0, 1'b0);
        wait_finish(1'b0);
        build_expected(DEPTH);
        check_writes("full_depth");
        total++;
        if (mem_addr !== 5'd31 || mem_wdata !== exp_q[DEPTH-1][31:0]) begin
            bad++;
            $display("FAIL full_hold: got addr=%0d data=%h required 31 %h", mem_addr, mem_wdata, exp_q[DEPTH-1][31:0]);
        end
    endtask

    task automatic test_random_stalls();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            fill_stream(4 * n);
            act_q.delete();
            do_start(n);
            drive_stream(4 * n, 1'b1, 1'b1);
            wait_finish(r[0]);
            build_expected(n);
            check_writes("random_stall");
        end
    endtask

    task automatic test_reset_mid();
        fill_stream(8);
        act_q.delete();
        do_start(2);
        drive_stream(7, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({byte_ready, mem_we, busy, done, error, core_hold} !== 6'b000001 ||
            mem_addr !== 5'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b we=%b busy=%b done=%b err=%b hold=%b addr=%0d data=%h required 0 0 0 0 0 1 0 0",
                     byte_ready, mem_we, busy, done, error, core_hold, mem_addr, mem_wdata);
        end
        total++;
        if (act_q.size() != 1) begin
            bad++;
            $display("FAIL mid_reset_writes: got %0d required 1", act_q.size());
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        fill_stream(4);
        do_start(1);
        drive_stream(4, 1'b0, 1'b0);
        total++;
        if (mem_we !== 1'b1) begin
            bad++;
            $display("FAIL pulse_before_reset: got we=%b required 1", mem_we);
        end
        reset = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL pulse_reset: got we=%b addr=%0d data=%h required 0 0 0", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        fill_stream(4);
        act_q.delete();
        do_start(1);
        drive_stream(4, 1'b0, 1'b0);
        wait_finish(1'b0);
        build_expected(1);
        check_writes("after_reset");
    endtask

    task automatic test_restart();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL restart_pre: got done=%b required 1", done);
        end
        fill_stream(4);
        act_q.delete();
        do_start(1);
        total++;
        if (done !== 1'b0 || core_hold !== 1'b1 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_drop: got done=%b hold=%b ready=%b required 0 1 1", done, core_hold, byte_ready);
        end
        drive_stream(4, 1'b0, 1'b0);
        wait_finish(1'b1);
        build_expected(1);
        check_writes("restart");
    endtask

    initial begin
        test_reset();
        test_two_words(1'b0, 1'b0);
        test_error();
        test_full_depth();
        test_two_words(1'b1, 1'b1);
        test_random_stalls();
        test_reset_mid();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that fills the instruction memory through its write port before the datapath starts fetching. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words. It writes each word at consecutive word addresses, the same word index the fetch side derives as PC/4. It holds the core off (`core_hold`) until the requested number of words has been written.

## Interface
- `DEPTH`, 32: instruction memory depth in words.
- `ADDR_W`, 5: word-address width, equal to log2(DEPTH).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (clock is one clock; reset asynchronous active-low, fixed).
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERR.
- `word_count`  in  ADDR_W+1  number of words to load; sampled on the `start` cycle.
- `byte_valid`  in  1  the source presents `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `mem_we`  out  1  single-cycle write strobe to the instruction memory.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  instruction word to write.
- `busy`  out  1  high in LOAD and WRITE.
- `done`  out  1  load completed; sticky until the next accepted `start`.
- `error`  out  1  illegal `word_count`; sticky until the next accepted `start`.
- `core_hold`  out  1  keeps the core in reset; low only in DONE.

## Operation
- States:
  - IDLE: `start` captures `word_count`. If the count is in the range 1..DEPTH, go to LOAD. If it is 0 or greater than DEPTH, go to ERR.
  - LOAD: `byte_ready`=1. A byte is accepted on the cycle `byte_valid && byte_ready` is true. Byte k of the current word (k=0..3) goes into bits [8k+7:8k]. On acceptance of byte 3, go to WRITE.
  - WRITE: `mem_we`=1 for exactly one cycle, with `mem_addr` set to the word index and `mem_wdata` set to the packed word. `byte_ready`=0. Next: if index+1 == captured count, go to DONE. Otherwise increment the index, clear the byte counter and go to LOAD.
  - DONE: `done`=1 and `core_hold`=0. `start` restarts the load as in IDLE: `done` clears, index goes to 0, and the next state is LOAD or ERR.
  - ERR: `error`=1 and `core_hold`=1. `start` behaves as in IDLE.
- `start` is ignored in LOAD and WRITE.
- The captured count and index are held internally. Changes to `word_count` after the `start` cycle have no effect.
- Width rules:
  - The index is ADDR_W bits wide.
  - The comparison uses ADDR_W+1 bits, so `word_count`=DEPTH is legal and ends with the index equal to DEPTH-1. The index never wraps.
- `mem_wdata` and `mem_addr` hold their last values outside WRITE. They are meaningful only while `mem_we`=1.

## Timing
- Reset values:
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=0, `done`=0, `error`=0, `core_hold`=1.
  - State IDLE; byte counter and index both 0.
- `start` at edge n moves the state to LOAD, so `byte_ready`=1 after edge n.
- The write strobe is high for the cycle immediately after the edge that accepted byte 3. Latency is 1 cycle.
- Peak throughput is 4 bytes per 5 cycles, because `byte_ready` drops during WRITE.
- Source stalls (`byte_valid`=0) hold the byte counter. There is no timeout.
- `done` and `core_hold` change on the edge that leaves WRITE for the last word. The last `mem_we` pulse and `done`=1 are therefore never in the same cycle.
- Asserting `reset` mid-load aborts it asynchronously:
  - All outputs return to their reset values immediately, including `mem_we`, which drops even mid-pulse.
  - Partially written memory contents are left as they are.
- If `start` arrives together with the last-word WRITE, it is ignored. The block enters DONE.

## Structure
- Package `loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, LOAD, WRITE, DONE, ERR);
  - the constants `BYTES_PER_WORD`=4 and `DEFAULT_DEPTH`=32.
- Sub-module `byte_packer` has the following ports:
  - inputs: `clock`, `reset`, `clear`, `accept`, `byte_data`;
  - outputs: the 2-bit counter `last` (high when byte 3 is accepted) and the 32-bit `word`.
  - It contains the byte counter and the little-endian assembly register.
- The top level contains the FSM, the index/count registers and the output registers.

## Test plan
- `word_count`=2 with bytes 13,00,00,00,93,00,10,00 streamed back-to-back -> `mem_we` pulses at addr 0 with data 0x00000013 and at addr 1 with data 0x00100093, then `done`=1 and `core_hold`=0.
- `word_count`=0, and separately `word_count`=33 -> ERR, `error`=1, `core_hold`=1, no `mem_we` pulse; a following `start` with count 1 clears `error`.
- `word_count`=32 streaming 128 bytes -> last write at addr 31, no wrap to 0, `done`=1.
- `byte_valid` toggled randomly, plus `start` pulses during LOAD -> identical write sequence to the back-to-back case; the `start` pulses are ignored.
- `reset` asserted after byte 2 of word 1 -> outputs immediately return to their reset values; after release, a new load with count 1 writes at addr 0.
- Restart from DONE with `word_count`=1 -> `done` drops the cycle after `start` and reasserts after the single write.
